tile_row_fetcher: RTL



---
 rtl/tile_row_fetcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tile_row_fetcher.sv
// Per-pixel tile ID source for the 10x10 playfield: fetches one map row per
// tile row during h-blank into a double-buffered line store, then streams it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for the row trigger (DrawX==640 on lines 39,79,..,399)
// S_FETCH | issuing 10 reads, one per cycle
// S_DRAIN | last read data lands in the fill buffer
// S_DONE  | waiting for DrawX==799 to swap fill/active buffers
module tile_row_fetcher #(
    parameter  int MAP_COLS = 64,
    parameter  int ADDR_W   = 10,
    localparam int COL_W    = $clog2(MAP_COLS)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [COL_W-1:0]  scroll_col,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic [2:0]        blockID
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [3:0]          r_row;
    logic [3:0]          r_idx;
    logic [3:0]          r_wr_idx;
    logic                r_wr_en;
    logic [COL_W-1:0]    r_scroll_q;
    logic                r_sel;
    logic [2:0]          r_buf [2][10];
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [2:0]          r_bid;
    logic [3:0]          r_tile;
    logic [5:0]          r_sub;

    logic                w_trig;
    logic [3:0]          w_trig_row;
    logic [COL_W-1:0]    w_base_col;
    logic [COL_W-1:0]    w_next_col;
    logic [3:0]          w_ntile;
    logic [5:0]          w_nsub;
    logic                w_in_y;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [3:0] row,
                                                 input logic [COL_W-1:0] col);
        return (ADDR_W'(row) << COL_W) | ADDR_W'(col);
    endfunction

    always_comb begin
        w_trig     = 1'b0;
        w_trig_row = 4'd0;
        if (DrawX == 10'd640) begin
            for (int k = 0; k < 10; k++) begin
                if (DrawY == 10'(39 + 40 * k)) begin
                    w_trig     = 1'b1;
                    w_trig_row = 4'(k);
                end
            end
        end
    end

    // Row 0 uses the live scroll value since scroll_q is latched on this same edge.
    assign w_base_col = (w_trig_row == 4'd0) ? scroll_col : r_scroll_q;
    assign w_next_col = r_scroll_q + COL_W'(r_idx) + COL_W'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_row      <= 4'd0;
            r_idx      <= 4'd0;
            r_wr_idx   <= 4'd0;
            r_wr_en    <= 1'b0;
            r_scroll_q <= '0;
            r_sel      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            for (int b = 0; b < 2; b++)
                for (int t = 0; t < 10; t++)
                    r_buf[b][t] <= 3'd0;
        end else begin
            r_wr_en  <= r_rd_en;
            r_wr_idx <= r_idx;
            if (r_wr_en)
                r_buf[~r_sel][r_wr_idx] <= rd_data;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_row     <= w_trig_row;
                        if (w_trig_row == 4'd0)
                            r_scroll_q <= scroll_col;
                        r_idx     <= 4'd0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= f_addr(w_trig_row, w_base_col);
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_idx == 4'd9) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx     <= r_idx + 4'd1;
                        r_rd_addr <= f_addr(r_row, w_next_col);
                    end
                end
                S_DRAIN: r_state <= S_DONE;
                S_DONE: begin
                    if (DrawX == 10'd799) begin
                        r_sel   <= ~r_sel;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Counters hold the position of pixel DrawX; blockID is computed for DrawX+1.
    always_comb begin
        w_nsub  = r_sub + 6'd1;
        w_ntile = r_tile;
        if (r_sub == 6'd39) begin
            w_nsub  = 6'd0;
            w_ntile = r_tile + 4'd1;
        end
    end

    assign w_in_y = (DrawY >= 10'd40) && (DrawY < 10'd440);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tile <= 4'd0;
            r_sub  <= 6'd0;
            r_bid  <= 3'd0;
        end else if (DrawX == 10'd119) begin
            r_tile <= 4'd0;
            r_sub  <= 6'd0;
            r_bid  <= w_in_y ? r_buf[r_sel][0] : 3'd0;
        end else if ((DrawX >= 10'd120) && (DrawX <= 10'd518)) begin
            r_tile <= w_ntile;
            r_sub  <= w_nsub;
            r_bid  <= w_in_y ? r_buf[r_sel][w_ntile] : 3'd0;
        end else begin
            r_bid  <= 3'd0;
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign blockID = r_bid;

endmodule
